// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the memory request arbiter: requester IDs and the
// request bundle carried on the sram-like address channel.
package mem_req_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Which requester owns a transaction. DATA is the reset/idle grant.
  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } req_src_e;

  // Address-phase fields that travel together through the mux.
  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_arbiter_req_id_fifo.sv
// In-order queue of requester IDs for accepted-but-unanswered transactions.
// Push and pop in the same cycle advance both pointers and leave the count alone.
module req_id_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     push_i,
  input  req_src_e push_id_i,
  input  logic     pop_i,
  output req_src_e head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  req_src_e   id_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = id_q[rd_ptr_q];

  // Never overrun or underrun, whatever the caller does.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointers and count; DEPTH is a power of 2 so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) id_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between instruction fetch and the data
// port. Address phase is arbitrated combinationally (data wins, grant frozen
// while a request waits for addr_ok); responses are routed back in order via
// an ID queue.
//
// Handshake: a request transfers in the cycle where mem_req && mem_addr_ok
// are both high; a response transfers in the cycle mem_data_ok is high, in
// issue order, no earlier than the cycle after its address transfer.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  mem_req_t inst_bus, data_bus, mem_bus;
  req_src_e grant, grant_q, grant_d;
  req_src_e head_id;
  logic     lock_q, lock_d;
  logic     sel_req;
  logic     full, empty;
  logic     push, pop;

  assign inst_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};

  // Grant: frozen while locked, otherwise data has priority over fetch.
  always_comb begin
    grant = REQ_DATA;
    if (lock_q)        grant = grant_q;
    else if (data_req) grant = REQ_DATA;
    else if (inst_req) grant = REQ_INST;
  end

  // Request mux; fields read as zero when nobody is requesting.
  always_comb begin
    sel_req = (grant == REQ_DATA) ? data_req : inst_req;
    mem_bus = '0;
    if (inst_req || data_req) mem_bus = (grant == REQ_DATA) ? data_bus : inst_bus;
  end

  // Full blocks new requests; a same-cycle pop deliberately does not help,
  // keeping mem_data_ok off the mem_req path.
  assign mem_req   = sel_req && !full;
  assign mem_wr    = mem_bus.wr;
  assign mem_size  = mem_bus.size;
  assign mem_wstrb = mem_bus.wstrb;
  assign mem_addr  = mem_bus.addr;
  assign mem_wdata = mem_bus.wdata;

  assign push         = mem_req && mem_addr_ok;
  assign inst_addr_ok = push && (grant == REQ_INST);
  assign data_addr_ok = push && (grant == REQ_DATA);

  // A stray mem_data_ok with nothing outstanding is dropped here.
  assign pop          = mem_data_ok && !empty;
  assign inst_data_ok = pop && (head_id == REQ_INST);
  assign data_data_ok = pop && (head_id == REQ_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign busy         = !empty;

  // Lock holds the grant across a stalled address phase until it is accepted.
  always_comb begin
    lock_d  = lock_q;
    grant_d = grant;
    if (mem_addr_ok)  lock_d = 1'b0;
    else if (mem_req) lock_d = 1'b1;
  end

  // Lock/grant state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q  <= 1'b0;
      grant_q <= REQ_DATA;
    end else begin
      lock_q  <= lock_d;
      grant_q <= grant_d;
    end
  end

  req_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push_i    (push),
    .push_id_i (grant),
    .pop_i     (pop),
    .head_o    (head_id),
    .full_o    (full),
    .empty_o   (empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: reset, priority, lock, full,
// back-to-back wrap with same-cycle push/pop, and reset mid-operation.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        allow_stray = 1'b0;
  logic [0:0]  exp_q[$];   // expected response source, 1 = DATA
  logic [0:0]  exp_src;
  logic [9:0]  pat;

  mem_req_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Responses must only arrive while something is outstanding.
  always @(negedge clk) begin
    if (resetn === 1'b1 && mem_data_ok === 1'b1 && !allow_stray) begin
      n_cmp++;
      assert (busy === 1'b1) else begin
        n_err++;
        $error("FAIL protocol_stray_data_ok: busy=%0b required 1", busy);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();

    // ---- reset then idle
    step(); step(); step();
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_fields", {mem_wr, mem_size, mem_wstrb, mem_addr[24:0]}, 0);
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    resetn = 1'b1;
    step();
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_mem_req", {31'd0, mem_req}, 0);

    // ---- simultaneous request: data wins
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2; inst_wstrb = 4'h0;
    data_req = 1; data_addr = 32'h8000_1000; data_wr = 1; data_size = 2'd2;
    data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    mem_addr_ok = 1;
    #1;
    chk("sim_mem_addr", mem_addr, 32'h8000_1000);
    chk("sim_mem_wr", {31'd0, mem_wr}, 1);
    chk("sim_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sim_data_addr_ok", {31'd0, data_addr_ok}, 1);
    chk("sim_inst_addr_ok", {31'd0, inst_addr_ok}, 0);
    step();
    data_req = 0; data_wr = 0;
    #1;
    chk("sim2_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("sim2_mem_wr", {31'd0, mem_wr}, 0);
    chk("sim2_inst_addr_ok", {31'd0, inst_addr_ok}, 1);
    chk("sim2_busy", {31'd0, busy}, 1);
    step();
    inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'h11;
    #1;
    chk("sim_resp1_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
    chk("sim_resp1_rdata", data_rdata, 32'h11);
    chk("sim_resp1_mem_req", {31'd0, mem_req}, 0);
    step();
    mem_rdata = 32'h22;
    #1;
    chk("sim_resp2_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'b10);
    chk("sim_resp2_rdata", inst_rdata, 32'h22);
    step();
    mem_data_ok = 0;
    #1;
    chk("sim_drain_busy", {31'd0, busy}, 0);

    // ---- lock: inst stalls 3 cycles, data rises meanwhile
    inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 0;
    #1;
    chk("lock_c1_addr", mem_addr, 32'hBFC0_0000);
    chk("lock_c1_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
    step();
    data_req = 1; data_addr = 32'h8000_2000;
    #1;
    chk("lock_c2_addr", mem_addr, 32'hBFC0_0000);
    chk("lock_c2_mem_req", {31'd0, mem_req}, 1);
    step();
    #1;
    chk("lock_c3_addr", mem_addr, 32'hBFC0_0000);
    step();
    mem_addr_ok = 1;
    #1;
    chk("lock_c4_addr", mem_addr, 32'hBFC0_0000);
    chk("lock_c4_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'b10);
    step();
    inst_req = 0;
    #1;
    chk("lock_c5_addr", mem_addr, 32'h8000_2000);
    chk("lock_c5_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'b01);
    step();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    chk("lock_resp1", {30'd0, inst_data_ok, data_data_ok}, 32'b10);
    step();
    #1;
    chk("lock_resp2", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
    step();
    mem_data_ok = 0;
    #1;
    chk("lock_busy", {31'd0, busy}, 0);

    // ---- full: four accepts with no responses
    data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      data_addr = 32'h8000_3000 + 32'(i * 4);
      #1;
      chk("full_accept", {31'd0, data_addr_ok}, 1);
      step();
    end
    #1;
    chk("full_mem_req", {31'd0, mem_req}, 0);
    chk("full_addr_ok", {31'd0, data_addr_ok}, 0);
    chk("full_busy", {31'd0, busy}, 1);
    mem_data_ok = 1;
    #1;
    chk("full_pop_no_unblock", {31'd0, mem_req}, 0);
    chk("full_pop_data_ok", {31'd0, data_data_ok}, 1);
    step();
    mem_data_ok = 0;
    #1;
    chk("full_reassert", {31'd0, mem_req}, 1);
    chk("full_reaccept", {31'd0, data_addr_ok}, 1);
    step();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_drain", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
      step();
    end
    mem_data_ok = 0;
    #1;
    chk("full_drain_busy", {31'd0, busy}, 0);

    // ---- wrap: 10 back-to-back accepts, response every cycle from cycle 1
    pat = 10'b1011001101;
    for (int i = 0; i <= 10; i++) begin
      inst_req = 0; data_req = 0;
      if (i < 10) begin
        if (pat[i]) begin data_req = 1; data_addr = 32'h8000_4000 + 32'(i * 4); end
        else begin inst_req = 1; inst_addr = 32'hBFC0_1000 + 32'(i * 4); end
        mem_addr_ok = 1;
      end else begin
        mem_addr_ok = 0;
      end
      mem_data_ok = (i >= 1);
      mem_rdata = 32'hA0 + 32'(i);
      #1;
      if (i < 10) begin
        chk("wrap_addr", mem_addr,
            pat[i] ? 32'h8000_4000 + 32'(i * 4) : 32'hBFC0_1000 + 32'(i * 4));
        chk("wrap_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, pat[i] ? 32'b01 : 32'b10);
        exp_q.push_back(pat[i]);
      end
      if (i >= 1) begin
        exp_src = exp_q.pop_front();
        chk("wrap_route", {30'd0, inst_data_ok, data_data_ok}, exp_src ? 32'b01 : 32'b10);
        chk("wrap_rdata", exp_src ? data_rdata : inst_rdata, 32'hA0 + 32'(i));
        chk("wrap_busy", {31'd0, busy}, 1);
      end
      step();
    end
    idle_inputs();
    #1;
    chk("wrap_busy_end", {31'd0, busy}, 0);
    chk("wrap_queue_empty", 32'(exp_q.size()), 0);

    // ---- reset mid-operation
    data_req = 1; mem_addr_ok = 1;
    step(); step(); step();
    idle_inputs();
    resetn = 1'b0;
    #1;
    chk("mid_busy_before", {31'd0, busy}, 1);
    step();
    resetn = 1'b1;
    #1;
    chk("mid_busy_after", {31'd0, busy}, 0);
    allow_stray = 1'b1;
    mem_data_ok = 1; mem_rdata = 32'h55;
    #1;
    chk("mid_stray_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
    step();
    mem_data_ok = 0;
    allow_stray = 1'b0;
    #1;
    chk("mid_busy_final", {31'd0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (IF) and the data requester (pre_MEM data port).
- Sits between the pipeline and the cache/AXI bridge.
- Arbitrates address-phase requests and tracks in-flight transactions in a small in-order ID queue, so each data_ok/rdata is routed back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions; power of 2, at least 2.
- CNT_W, $clog2(MAX_OUTSTANDING)+1, width of the in-flight counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active low
- inst_req  in  1  IF request
- inst_wr  in  1  always 0 in normal use; passed through
- inst_size  in  2  size
- inst_wstrb  in  4  byte strobe
- inst_addr  in  32  physical address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  IF request accepted
- inst_data_ok  out  1  IF response valid
- inst_rdata  out  32  IF read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  pre_MEM request, same meaning as inst_*
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  downstream request
- mem_addr_ok  in  1  downstream accept
- mem_data_ok  in  1  downstream response; in order, at earliest the cycle after its addr_ok
- mem_rdata  in  32  downstream read data
- busy  out  1  in-flight count is non-zero

Behaviour:
- Reset (resetn=0 at clk edge): in-flight count 0, queue pointers 0, lock 0, grant = DATA.
  - Consequently all outputs are 0 while reset is held, and in the first cycle after release unless inputs are active.
- Grant selection, combinational, when lock=0: data_req wins over inst_req; inst is granted only when data_req=0.
- Lock: set at the clock edge when mem_req=1 and mem_addr_ok=0. Cleared on mem_addr_ok.
  - While lock=1 the grant is frozen, so mem_* stays stable until accepted, even if the other requester asserts.
- full = (count == MAX_OUTSTANDING).
- mem_req = (granted requester's req) && !full. A pop in the same cycle does not unblock full; this is deliberate, to avoid a data_ok-to-req combinational path.
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata are a pure mux of the granted requester's fields. They are 0 when neither requester is requesting.
- inst_addr_ok = mem_req && mem_addr_ok && grant==INST. data_addr_ok likewise for DATA. At most one is high per cycle.
- Push: on an addr_ok handshake, the grant ID is written at the queue tail.
- Pop: on mem_data_ok, the head ID is popped.
  - head==INST: inst_data_ok=1. head==DATA: data_data_ok=1.
  - mem_rdata is driven to both rdata outputs unconditionally.
- Same-cycle push and pop: count unchanged, both pointers advance. Pointers wrap modulo MAX_OUTSTANDING.
- mem_data_ok while count==0 is a protocol violation. It is ignored: no *_data_ok, no pointer/count change. The bench asserts this case never occurs.
- No flush input. Responses for squashed instructions still drain and route normally; each requester discards them itself.
- Writes also receive a data_ok (pre_MEM/MEM count them as completions).
- Latency:
  - address path 0 cycles (combinational);
  - response routing 0 cycles from mem_data_ok;
  - a queue entry is visible to pop in the cycle after its push.

Decomposition:
- Shared in cpu_defs.svh:
  - typedef enum logic {REQ_INST, REQ_DATA} req_src_e;
  - typedef struct mem_req_t {wr, size, wstrb, addr, wdata}, used for the inst/data/mem request bundles internally.
- One sub-module: req_id_fifo (synchronous FIFO of req_src_e, depth MAX_OUTSTANDING), holding the pointers and count and exposing push, pop, head, full, empty.

Test Plan:
- Reset then idle: resetn=0 for 3 cycles, all requests 0 -> every output 0; busy=0 after release.
- Simultaneous request: inst_req=1 (addr 0xBFC00000) and data_req=1 (addr 0x80001000), mem_addr_ok=1 -> mem_addr=0x80001000 and data_addr_ok=1 in that cycle. Next cycle (data_req=0) inst accepted. Two data_ok responses with rdata 0x11, 0x22 -> data_data_ok then inst_data_ok, in that order.
- Lock: inst granted while mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays 0xBFC00000 until addr_ok; data is accepted afterwards.
- Full: MAX_OUTSTANDING=4, four accepts with no data_ok -> mem_req=0 and busy=1. One data_ok -> mem_req reasserts the following cycle.
- Wrap and same cycle: 10 back-to-back accepts with a data_ok every cycle from cycle 1 -> count never exceeds 1; the source routing of all 10 responses matches issue order.
- Reset mid-operation: 3 outstanding, resetn=0 for 1 cycle -> busy=0. A subsequent stray mem_data_ok produces no *_data_ok.
